text_write_controller: RTL and testbench

TEXT_WRITE_CONTROLLER -- requirements
Module: text_write_controller

---
 rtl/text_write_controller_pkg.sv | 26 ++
 rtl/text_cursor_step.sv | 34 +++
 rtl/text_write_controller.sv | 143 ++++++++++++++
 tb/tb_text_write_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/text_write_controller_pkg.sv
// Shared constants for the text write path: op-codes, screen geometry defaults,
// coordinate width and the coordinate clamp used by SETPOS.
package text_write_controller_pkg;

  localparam int COORD_W      = 7;
  localparam int COLS_DEFAULT = 100;
  localparam int ROWS_DEFAULT = 75;

  typedef enum logic [1:0] {
    OP_PUTCHAR = 2'b00,
    OP_SETPOS  = 2'b01,
    OP_CLEAR   = 2'b10,
    OP_NEWLINE = 2'b11
  } text_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } text_state_e;

  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/text_cursor_step.sv
// Combinational next position on a COLS x ROWS grid: advance one cell in
// row-major order, or jump to the start of the next row; both wrap to (0,0).
module text_cursor_step
  import text_write_controller_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic               i_newline,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y
);

  localparam logic [COORD_W-1:0] MAX_X = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(ROWS - 1);

  logic [COORD_W-1:0] w_y_inc;

  assign w_y_inc = (i_y == MAX_Y) ? '0 : i_y + COORD_W'(1);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    o_x = '0;
    o_y = i_y;
    if (i_newline || i_x == MAX_X) begin
      o_y = w_y_inc;
    end else begin
      o_x = i_x + COORD_W'(1);
    end
  end

endmodule

// File: rtl/text_write_controller.sv
// Command-driven text cursor: PUTCHAR/SETPOS/NEWLINE update the cursor and
// emit cell writes; CLEAR streams one fill write per cycle over the screen.
module text_write_controller
  import text_write_controller_pkg::*;
#(
  parameter int COLS   = COLS_DEFAULT,
  parameter int ROWS   = ROWS_DEFAULT,
  parameter int ATTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [ATTR_W-1:0]  cmd_data,
  output logic               write,
  output logic [COORD_W-1:0] xtextwrite,
  output logic [COORD_W-1:0] ytextwrite,
  output logic [ATTR_W-1:0]  value,
  output logic [COORD_W-1:0] cursor_x,
  output logic [COORD_W-1:0] cursor_y,
  output logic               busy
);

  localparam logic [COORD_W-1:0] MAX_X = COORD_W'(COLS - 1);
  localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(ROWS - 1);

  text_state_e        r_state, w_next_state;
  logic [COORD_W-1:0] r_cur_x, r_cur_y, r_scan_x, r_scan_y;
  logic [COORD_W-1:0] r_xtextwrite, r_ytextwrite;
  logic [ATTR_W-1:0]  r_fill, r_value;
  logic               r_write;

  text_op_e           w_op;
  logic               w_accept, w_clear_last;
  logic [COORD_W-1:0] w_cur_next_x, w_cur_next_y;
  logic [COORD_W-1:0] w_scan_in_x, w_scan_in_y, w_scan_next_x, w_scan_next_y;

  assign w_op     = text_op_e'(cmd_op);
  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  // The last strobe of a fill is recognised from the write address on the outputs.
  assign w_clear_last = (r_xtextwrite == MAX_X) && (r_ytextwrite == MAX_Y);

  // While idle the scan step sees (0,0), so accepting CLEAR preloads the second cell.
  assign w_scan_in_x = (r_state == ST_IDLE) ? '0 : r_scan_x;
  assign w_scan_in_y = (r_state == ST_IDLE) ? '0 : r_scan_y;

  text_cursor_step #(.COLS(COLS), .ROWS(ROWS)) u_cursor_step (
    .i_x       (r_cur_x),
    .i_y       (r_cur_y),
    .i_newline (w_op == OP_NEWLINE),
    .o_x       (w_cur_next_x),
    .o_y       (w_cur_next_y)
  );

  text_cursor_step #(.COLS(COLS), .ROWS(ROWS)) u_scan_step (
    .i_x       (w_scan_in_x),
    .i_y       (w_scan_in_y),
    .i_newline (1'b0),
    .o_x       (w_scan_next_x),
    .o_y       (w_scan_next_y)
  );

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept && w_op == OP_CLEAR) w_next_state = ST_CLEAR;
      ST_CLEAR: if (w_clear_last) w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write      <= 1'b0;
      r_xtextwrite <= '0;
      r_ytextwrite <= '0;
      r_value      <= '0;
      r_fill       <= '0;
      r_cur_x      <= '0;
      r_cur_y      <= '0;
      r_scan_x     <= '0;
      r_scan_y     <= '0;
    end else begin
      r_write <= 1'b0;
      if (w_accept) begin
        unique case (w_op)
          OP_PUTCHAR: begin
            r_write      <= 1'b1;
            r_xtextwrite <= r_cur_x;
            r_ytextwrite <= r_cur_y;
            r_value      <= cmd_data;
            r_cur_x      <= w_cur_next_x;
            r_cur_y      <= w_cur_next_y;
          end
          OP_SETPOS: begin
            r_cur_x <= clamp_coord(cmd_x, MAX_X);
            r_cur_y <= clamp_coord(cmd_y, MAX_Y);
          end
          OP_NEWLINE: begin
            r_cur_x <= w_cur_next_x;
            r_cur_y <= w_cur_next_y;
          end
          OP_CLEAR: begin
            r_fill       <= cmd_data;
            r_write      <= 1'b1;
            r_xtextwrite <= '0;
            r_ytextwrite <= '0;
            r_value      <= cmd_data;
            r_scan_x     <= w_scan_next_x;
            r_scan_y     <= w_scan_next_y;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
          end
        endcase
      end else if (r_state == ST_CLEAR && !w_clear_last) begin
        r_write      <= 1'b1;
        r_xtextwrite <= r_scan_x;
        r_ytextwrite <= r_scan_y;
        r_value      <= r_fill;
        r_scan_x     <= w_scan_next_x;
        r_scan_y     <= w_scan_next_y;
      end
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state == ST_CLEAR);
  assign write      = r_write;
  assign xtextwrite = r_xtextwrite;
  assign ytextwrite = r_ytextwrite;
  assign value      = r_value;
  assign cursor_x   = r_cur_x;
  assign cursor_y   = r_cur_y;

endmodule

// File: tb/tb_text_write_controller.sv
// Directed bench for text_write_controller at the default 100x75 geometry.
module tb_text_write_controller;

  localparam logic [1:0] OP_PUTCHAR = 2'b00;
  localparam logic [1:0] OP_SETPOS  = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;
  localparam logic [1:0] OP_NEWLINE = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [6:0]  cmd_x = '0;
  logic [6:0]  cmd_y = '0;
  logic [15:0] cmd_data = '0;
  logic        write;
  logic [6:0]  xtextwrite, ytextwrite, cursor_x, cursor_y;
  logic [15:0] value;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  text_write_controller dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_data   (cmd_data),
    .write      (write),
    .xtextwrite (xtextwrite),
    .ytextwrite (ytextwrite),
    .value      (value),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Offer one command on an idle DUT; returns at the negedge after acceptance.
  task automatic send(input logic [1:0] op, input logic [6:0] x, input logic [6:0] y,
                      input logic [15:0] d);
    @(negedge clk);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_data = d; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if (write !== 1'b0) $display("FAIL reset_write: got %0b want 0", write); else pass_cnt++;
    total_cnt++; if ({xtextwrite, ytextwrite, value} !== '0)
      $display("FAIL reset_wr_regs: got x=%0d y=%0d v=%h want 0", xtextwrite, ytextwrite, value); else pass_cnt++;
    total_cnt++; if ({cursor_x, cursor_y} !== '0)
      $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", cmd_ready); else pass_cnt++;
  endtask

  task automatic test_putchar();
    send(OP_PUTCHAR, 7'd0, 7'd0, 16'h0141);
    total_cnt++; if ({write, xtextwrite, ytextwrite, value} !== {1'b1, 7'd0, 7'd0, 16'h0141})
      $display("FAIL put_strobe: got w=%0b (%0d,%0d) v=%h want w=1 (0,0) v=0141",
               write, xtextwrite, ytextwrite, value); else pass_cnt++;
    total_cnt++; if ({cursor_x, cursor_y} !== {7'd1, 7'd0})
      $display("FAIL put_cursor: got (%0d,%0d) want (1,0)", cursor_x, cursor_y); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({write, value} !== {1'b0, 16'h0141})
      $display("FAIL put_idle_hold: got w=%0b v=%h want w=0 v=0141", write, value); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    cmd_op = OP_PUTCHAR; cmd_data = 16'hA001; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_data = 16'hA002;
    total_cnt++; if ({write, xtextwrite, ytextwrite, value} !== {1'b1, 7'd1, 7'd0, 16'hA001})
      $display("FAIL b2b_first: got w=%0b (%0d,%0d) v=%h want w=1 (1,0) v=a001",
               write, xtextwrite, ytextwrite, value); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    total_cnt++; if ({write, xtextwrite, ytextwrite, value} !== {1'b1, 7'd2, 7'd0, 16'hA002})
      $display("FAIL b2b_second: got w=%0b (%0d,%0d) v=%h want w=1 (2,0) v=a002",
               write, xtextwrite, ytextwrite, value); else pass_cnt++;
    total_cnt++; if ({cursor_x, cursor_y} !== {7'd3, 7'd0})
      $display("FAIL b2b_cursor: got (%0d,%0d) want (3,0)", cursor_x, cursor_y); else pass_cnt++;
  endtask

  task automatic test_setpos_wrap();
    send(OP_SETPOS, 7'd99, 7'd74, 16'h0);
    total_cnt++; if ({write, cursor_x, cursor_y} !== {1'b0, 7'd99, 7'd74})
      $display("FAIL setpos: got w=%0b (%0d,%0d) want w=0 (99,74)", write, cursor_x, cursor_y); else pass_cnt++;
    send(OP_PUTCHAR, 7'd0, 7'd0, 16'h0042);
    total_cnt++; if ({write, xtextwrite, ytextwrite, value} !== {1'b1, 7'd99, 7'd74, 16'h0042})
      $display("FAIL wrap_strobe: got w=%0b (%0d,%0d) v=%h want w=1 (99,74) v=0042",
               write, xtextwrite, ytextwrite, value); else pass_cnt++;
    total_cnt++; if ({cursor_x, cursor_y} !== {7'd0, 7'd0})
      $display("FAIL wrap_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); else pass_cnt++;
    send(OP_SETPOS, 7'd99, 7'd3, 16'h0);
    send(OP_PUTCHAR, 7'd0, 7'd0, 16'h0043);
    total_cnt++; if ({cursor_x, cursor_y} !== {7'd0, 7'd4})
      $display("FAIL eol_cursor: got (%0d,%0d) want (0,4)", cursor_x, cursor_y); else pass_cnt++;
  endtask

  task automatic test_clamp_newline();
    send(OP_SETPOS, 7'd120, 7'd90, 16'h0);
    total_cnt++; if ({cursor_x, cursor_y} !== {7'd99, 7'd74})
      $display("FAIL clamp: got (%0d,%0d) want (99,74)", cursor_x, cursor_y); else pass_cnt++;
    send(OP_NEWLINE, 7'd0, 7'd0, 16'h0);
    total_cnt++; if ({write, cursor_x, cursor_y} !== {1'b0, 7'd0, 7'd0})
      $display("FAIL newline_wrap: got w=%0b (%0d,%0d) want w=0 (0,0)", write, cursor_x, cursor_y); else pass_cnt++;
    send(OP_SETPOS, 7'd5, 7'd3, 16'h0);
    send(OP_NEWLINE, 7'd0, 7'd0, 16'h0);
    total_cnt++; if ({cursor_x, cursor_y} !== {7'd0, 7'd4})
      $display("FAIL newline_mid: got (%0d,%0d) want (0,4)", cursor_x, cursor_y); else pass_cnt++;
  endtask

  task automatic test_clear();
    int n = 0, coord_err = 0, busy_err = 0;
    logic [6:0] ex = '0, ey = '0, lx = '0, ly = '0;
    send(OP_SETPOS, 7'd10, 7'd10, 16'h0);
    send(OP_CLEAR, 7'd0, 7'd0, 16'h0720);
    while (write === 1'b1 && n < 8000) begin
      if (xtextwrite !== ex || ytextwrite !== ey || value !== 16'h0720) coord_err++;
      if (busy !== 1'b1) busy_err++;
      lx = xtextwrite; ly = ytextwrite;
      if (ex == 7'd99) begin ex = 7'd0; ey = ey + 7'd1; end else ex = ex + 7'd1;
      n++;
      @(negedge clk);
    end
    total_cnt++; if (n !== 7500) $display("FAIL clear_count: got %0d strobes want 7500", n); else pass_cnt++;
    total_cnt++; if (coord_err !== 0) $display("FAIL clear_order: got %0d bad strobes want 0", coord_err); else pass_cnt++;
    total_cnt++; if (busy_err !== 0) $display("FAIL clear_busy: got %0d low-busy strobes want 0", busy_err); else pass_cnt++;
    total_cnt++; if ({lx, ly} !== {7'd99, 7'd74})
      $display("FAIL clear_last: got (%0d,%0d) want (99,74)", lx, ly); else pass_cnt++;
    total_cnt++; if ({busy, cmd_ready} !== 2'b01)
      $display("FAIL clear_done: got busy=%0b ready=%0b want busy=0 ready=1", busy, cmd_ready); else pass_cnt++;
    total_cnt++; if ({cursor_x, cursor_y} !== {7'd0, 7'd0})
      $display("FAIL clear_cursor: got (%0d,%0d) want (0,0)", cursor_x, cursor_y); else pass_cnt++;
  endtask

  task automatic test_held_during_clear();
    int low = 0;
    send(OP_CLEAR, 7'd0, 7'd0, 16'h0000);
    cmd_op = OP_PUTCHAR; cmd_data = 16'h0055; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && low < 8000) begin
      low++;
      @(negedge clk);
    end
    total_cnt++; if (low !== 7500) $display("FAIL held_ready_low: got %0d cycles want 7500", low); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    total_cnt++; if ({write, xtextwrite, ytextwrite, value} !== {1'b1, 7'd0, 7'd0, 16'h0055})
      $display("FAIL held_strobe: got w=%0b (%0d,%0d) v=%h want w=1 (0,0) v=0055",
               write, xtextwrite, ytextwrite, value); else pass_cnt++;
    total_cnt++; if ({cursor_x, cursor_y} !== {7'd1, 7'd0})
      $display("FAIL held_cursor: got (%0d,%0d) want (1,0)", cursor_x, cursor_y); else pass_cnt++;
  endtask

  task automatic test_reset_during_clear();
    int late = 0;
    send(OP_CLEAR, 7'd0, 7'd0, 16'h1111);
    repeat (299) @(negedge clk);
    total_cnt++; if ({write, xtextwrite, ytextwrite} !== {1'b1, 7'd99, 7'd2})
      $display("FAIL abort_strobe300: got w=%0b (%0d,%0d) want w=1 (99,2)", write, xtextwrite, ytextwrite); else pass_cnt++;
    #1 reset = 1'b1;
    #1;
    total_cnt++; if ({write, busy} !== 2'b00)
      $display("FAIL abort_async: got w=%0b busy=%0b want 0 0", write, busy); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (write !== 1'b0) late++;
    end
    total_cnt++; if (late !== 0) $display("FAIL abort_no_strobes: got %0d strobes want 0", late); else pass_cnt++;
    total_cnt++; if ({cmd_ready, busy, cursor_x, cursor_y} !== {2'b10, 7'd0, 7'd0})
      $display("FAIL abort_idle: got ready=%0b busy=%0b (%0d,%0d) want 1 0 (0,0)",
               cmd_ready, busy, cursor_x, cursor_y); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_putchar();
    test_back_to_back();
    test_setpos_wrap();
    test_clamp_newline();
    test_clear();
    test_held_during_clear();
    test_reset_during_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
